// File: rtl/capture_readout_if.sv
// Sample stream from the capture readout controller to its consumer.
interface capture_readout_if #(
  parameter int OW = 16
);
  logic [OW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast;

  modport master (output m_tdata, output m_tvalid, output m_tlast, input m_tready);
  modport slave  (input m_tdata, input m_tvalid, input m_tlast, output m_tready);
endinterface

// File: rtl/capture_readout.sv
// Read-side controller for the trigger-capture RAM: unrolls the circular
// buffer from the pre-trigger start point and streams it out with backpressure.
//
// state | meaning
// IDLE  | waiting for a start request
// ARMED | start accepted, waiting for the capture side to stop
// READ  | issuing RAM addresses
// DRAIN | all addresses issued, flushing the remaining words
module capture_readout #(
  parameter int AW     = 12,
  parameter int DW     = 14,
  parameter int OW     = 16,
  parameter bit SIGNED = 1'b1
) (
  input  logic          clkb,
  input  logic          rst,
  input  logic          start,
  input  logic          enabled,
  input  logic [AW-1:0] addr_trig,
  input  logic [AW-1:0] pnts_after_trig,
  input  logic [AW:0]   num_samples,
  output logic [AW-1:0] addrb,
  input  logic [DW-1:0] dob,
  capture_readout_if.master m_axis,
  output logic          busy,
  output logic          done,
  output logic          error
);

  typedef enum logic [1:0] {IDLE, ARMED, READ, DRAIN} state_t;

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE   = {{AW{1'b0}}, 1'b1};

  state_t        state;
  logic          ena_q1, ena_s;
  logic [AW:0]   n_lat, issued, captured;
  // a_pend: word at the current addrb not yet captured; a_ready: dob already
  // shows that word (addrb held for a cycle, so dob stays valid while held);
  // b_pend: previous word is on dob now and must be captured this edge.
  logic          a_pend, a_ready, b_pend;
  logic [OW-1:0] fifo_data [2];
  logic [1:0]    fifo_last;
  logic          wr_ptr, rd_ptr;
  logic [1:0]    cnt;
  logic          in_run, pop, room, cap_a, cap, issue, start_ok;
  logic [1:0]    cnt_after_pop, fifo_after;
  logic [OW-1:0] dob_ext;

  assign m_axis.m_tvalid = (cnt != 2'd0);
  assign m_axis.m_tdata  = fifo_data[rd_ptr];
  assign m_axis.m_tlast  = m_axis.m_tvalid && fifo_last[rd_ptr];

  // Sample extension to the output width.
  always_comb begin
    dob_ext = OW'(dob);
    if (SIGNED) dob_ext = OW'($signed(dob));
  end

  // Issue/capture decisions; a new address is only issued when every word
  // still in the RAM pipe is guaranteed a FIFO slot even if the sink stalls.
  always_comb begin
    in_run        = (state == READ) || (state == DRAIN);
    pop           = m_axis.m_tvalid && m_axis.m_tready;
    cnt_after_pop = cnt - {1'b0, pop};
    room          = (cnt_after_pop != 2'd2);
    cap_a         = in_run && a_pend && a_ready && room;
    cap           = in_run && (b_pend || cap_a);
    fifo_after    = cnt_after_pop + {1'b0, cap};
    issue         = (state == READ) && (issued != n_lat) &&
                    (!a_pend || cap_a || (fifo_after <= 2'd1));
    start_ok      = (num_samples != '0) && (num_samples <= DEPTH);
  end

  // Synchronizer, FSM, address generator and output FIFO.
  always_ff @(posedge clkb) begin
    if (rst) begin
      state        <= IDLE;
      ena_q1       <= 1'b0;
      ena_s        <= 1'b0;
      n_lat        <= '0;
      issued       <= '0;
      captured     <= '0;
      a_pend       <= 1'b0;
      a_ready      <= 1'b0;
      b_pend       <= 1'b0;
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_last    <= '0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      cnt          <= 2'd0;
      addrb        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      ena_q1 <= enabled;
      ena_s  <= ena_q1;
      done   <= 1'b0;
      error  <= 1'b0;

      if (pop) rd_ptr <= ~rd_ptr;
      if (cap) begin
        fifo_data[wr_ptr] <= dob_ext;
        fifo_last[wr_ptr] <= (captured == n_lat - ONE);
        wr_ptr            <= ~wr_ptr;
        captured          <= captured + ONE;
      end
      cnt <= fifo_after;

      if (in_run) begin
        a_ready <= !issue;
        b_pend  <= issue && a_pend && !cap_a;
        a_pend  <= issue || (a_pend && !cap_a);
      end
      if (issue) begin
        addrb  <= addrb + 1'b1;
        issued <= issued + ONE;
      end

      case (state)
        IDLE: begin
          if (start) begin
            if (start_ok) begin
              n_lat <= num_samples;
              busy  <= 1'b1;
              state <= ARMED;
            end else begin
              error <= 1'b1;
            end
          end
        end
        ARMED: begin
          if (!ena_s) begin
            addrb    <= addr_trig + pnts_after_trig - n_lat[AW-1:0];
            issued   <= ONE;
            captured <= '0;
            a_pend   <= 1'b1;
            a_ready  <= 1'b0;
            b_pend   <= 1'b0;
            state    <= READ;
          end
        end
        READ: begin
          if (issued == n_lat) state <= DRAIN;
        end
        DRAIN: begin
          if (pop && m_axis.m_tlast) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_capture_readout.sv
// Bench for capture_readout: vector table of readouts checked through a
// scoreboard, plus hand sequences for armed wait, errors and reset.
module tb_capture_readout;
  localparam int AW = 12;
  localparam int DW = 14;
  localparam int OW = 16;

  logic          clkb = 1'b0;
  logic          rst, start, enabled;
  logic [AW-1:0] addr_trig, pnts_after_trig, addrb, addrb_u;
  logic [AW:0]   num_samples;
  logic [DW-1:0] dob, dob_u;
  logic          busy, done, error, busy_u, done_u, error_u;

  capture_readout_if #(.OW(OW)) bus ();
  capture_readout_if #(.OW(OW)) bus_u ();
  assign bus_u.m_tready = bus.m_tready;

  always #5 clkb = ~clkb;

  capture_readout #(.AW(AW), .DW(DW), .OW(OW), .SIGNED(1'b1)) u_dut (
    .clkb(clkb), .rst(rst), .start(start), .enabled(enabled),
    .addr_trig(addr_trig), .pnts_after_trig(pnts_after_trig),
    .num_samples(num_samples), .addrb(addrb), .dob(dob), .m_axis(bus),
    .busy(busy), .done(done), .error(error));

  capture_readout #(.AW(AW), .DW(DW), .OW(OW), .SIGNED(1'b0)) u_dut_u (
    .clkb(clkb), .rst(rst), .start(start), .enabled(enabled),
    .addr_trig(addr_trig), .pnts_after_trig(pnts_after_trig),
    .num_samples(num_samples), .addrb(addrb_u), .dob(dob_u), .m_axis(bus_u),
    .busy(busy_u), .done(done_u), .error(error_u));

  logic [DW-1:0] ram [4096];
  always @(posedge clkb) begin
    dob   <= ram[addrb];
    dob_u <= ram[addrb_u];
  end

  typedef struct {
    logic [DW-1:0] raw;
    logic          last;
  } exp_t;

  typedef struct {
    logic [AW-1:0] trig;
    logic [AW-1:0] pnts;
    logic [AW:0]   n;
    int            mode;
    logic [AW-1:0] sa;
  } vec_t;

  exp_t          sbq[$];
  vec_t          vecs[6];
  int            checks = 0;
  int            errors = 0;
  int            xfer_cnt = 0;
  int            rmode = 0;
  int            cyc_r = 0;
  logic          first_seen = 1'b1;
  logic [OW-1:0] first_data, first_data_u;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Ready driver: 0 = always ready, 1 = 1,0,0,1 pattern, 2 = random.
  initial begin
    logic [3:0] pat;
    pat = 4'b1001;
    bus.m_tready = 1'b1;
    forever begin
      @(posedge clkb);
      #1;
      cyc_r++;
      case (rmode)
        1:       bus.m_tready = pat[cyc_r % 4];
        2:       bus.m_tready = 1'($urandom_range(0, 1));
        default: bus.m_tready = 1'b1;
      endcase
    end
  end

  // Output monitor: scoreboard compare on every transfer, stability under stall.
  initial begin
    logic          stall_prev;
    logic [OW-1:0] prev_data;
    exp_t          e;
    stall_prev = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clkb);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          chk("hold_valid", bus.m_tvalid, 1);
          chk("hold_data", bus.m_tdata, prev_data);
        end
        if (bus.m_tvalid && bus.m_tready) begin
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_word actual=%0h required=no_word", bus.m_tdata);
          end else begin
            e = sbq.pop_front();
            chk("data_signed", bus.m_tdata, {{(OW-DW){e.raw[DW-1]}}, e.raw});
            chk("data_unsigned", bus_u.m_tdata, {{(OW-DW){1'b0}}, e.raw});
            chk("tlast", bus.m_tlast, e.last);
          end
          if (!first_seen) begin
            first_seen   = 1'b1;
            first_data   = bus.m_tdata;
            first_data_u = bus_u.m_tdata;
          end
          xfer_cnt++;
        end
        stall_prev = bus.m_tvalid && !bus.m_tready;
        prev_data  = bus.m_tdata;
      end
    end
  end

  task automatic push_expected(input int trig, input int pnts, input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      int   a;
      a      = (trig + pnts - n + i) & 4095;
      e.raw  = ram[a];
      e.last = (i == n - 1);
      sbq.push_back(e);
    end
  endtask

  task automatic pulse_start(input int n);
    @(posedge clkb);
    #1;
    num_samples = (AW+1)'(n);
    start       = 1'b1;
    @(posedge clkb);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input logic [AW-1:0] sa, input int bound, input bit chk_addr,
                           output int ta, output int tv, output int td);
    ta = -1;
    tv = -1;
    td = -1;
    for (int c = 1; c <= bound; c++) begin
      @(negedge clkb);
      if (ta < 0 && addrb == sa) ta = c;
      if (tv < 0 && bus.m_tvalid) tv = c;
      if (done) begin
        td = c;
        break;
      end
    end
    chk("done_seen", td > 0, 1);
    if (td > 0) chk("busy_at_done", busy, 0);
    if (chk_addr) chk("start_addr_seen", ta > 0, 1);
    chk("sb_empty", sbq.size(), 0);
    @(negedge clkb);
    chk("done_one_cycle", done, 0);
  endtask

  initial begin
    int   ta, tv, td, base, tr;
    logic moved, err_seen;

    for (int i = 0; i < 4096; i++) ram[i] = DW'(i);
    ram[200] = 14'h2000;
    ram[201] = 14'h3fff;

    vecs[0] = '{12'd100,  12'd20, 13'd8,    0, 12'd112};
    vecs[1] = '{12'd4090, 12'd10, 13'd16,   0, 12'd4084};
    vecs[2] = '{12'd200,  12'd2,  13'd2,    0, 12'd200};
    vecs[3] = '{12'd500,  12'd12, 13'd32,   1, 12'd480};
    vecs[4] = '{12'd0,    12'd0,  13'd1,    0, 12'd4095};
    vecs[5] = '{12'd5,    12'd3,  13'd4096, 2, 12'd8};

    rst = 1'b1;
    start = 1'b0;
    enabled = 1'b0;
    addr_trig = '0;
    pnts_after_trig = '0;
    num_samples = 13'd1;
    repeat (3) @(posedge clkb);
    @(negedge clkb);
    chk("rst_addrb", addrb, 0);
    chk("rst_tvalid", bus.m_tvalid, 0);
    chk("rst_tdata", bus.m_tdata, 0);
    chk("rst_tlast", bus.m_tlast, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_u_outputs", {addrb_u, bus_u.m_tvalid, bus_u.m_tlast, busy_u, done_u, error_u}, 0);
    @(posedge clkb);
    #1 rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      addr_trig       = vecs[i].trig;
      pnts_after_trig = vecs[i].pnts;
      rmode           = vecs[i].mode;
      first_seen      = 1'b0;
      push_expected(int'(vecs[i].trig), int'(vecs[i].pnts), int'(vecs[i].n));
      pulse_start(int'(vecs[i].n));
      if (i == 3) enabled = 1'b1;
      wait_done(vecs[i].sa, int'(vecs[i].n) * 4 + 60, 1'b1, ta, tv, td);
      if (vecs[i].mode == 0) begin
        chk("lat_first_valid", tv - ta, 2);
        chk("lat_done", td - ta, int'(vecs[i].n) + 2);
      end
      if (i == 2) begin
        chk("sext_2000", first_data, 16'hE000);
        chk("zext_2000", first_data_u, 16'h2000);
      end
      enabled = 1'b0;
      repeat (3) @(posedge clkb);
      #1;
    end

    pulse_start(0);
    @(negedge clkb);
    chk("err_zero_pulse", error, 1);
    chk("err_zero_busy", busy, 0);
    @(negedge clkb);
    chk("err_zero_clear", error, 0);
    pulse_start(4097);
    @(negedge clkb);
    chk("err_big_pulse", error, 1);
    chk("err_big_busy", busy, 0);

    rmode = 0;
    addr_trig = 12'd300;
    pnts_after_trig = 12'd0;
    enabled = 1'b1;
    repeat (3) @(posedge clkb);
    pulse_start(10);
    base = int'(addrb);
    moved = 1'b0;
    err_seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clkb);
      if (int'(addrb) != base || bus.m_tvalid) moved = 1'b1;
      if (error) err_seen = 1'b1;
      if (c == 20) begin
        start = 1'b1;
        num_samples = '0;
      end
      if (c == 21) begin
        start = 1'b0;
        num_samples = 13'd10;
      end
      if (c == 30) addr_trig = 12'd310;
    end
    chk("armed_no_activity", moved, 0);
    chk("armed_busy", busy, 1);
    chk("start_while_busy_no_error", err_seen, 0);
    push_expected(310, 0, 10);
    @(posedge clkb);
    #1 enabled = 1'b0;
    tr = -1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clkb);
      if (int'(addrb) != base) begin
        tr = c;
        chk("armed_start_addr", addrb, 300);
        break;
      end
    end
    chk("armed_release_delay", (tr >= 3) && (tr <= 4), 1);
    addr_trig = 12'd999;
    wait_done(12'd300, 100, 1'b0, ta, tv, td);

    addr_trig = 12'd1000;
    pnts_after_trig = 12'd0;
    push_expected(1000, 0, 64);
    pulse_start(64);
    base = xfer_cnt;
    tr = -1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clkb);
      if (xfer_cnt >= base + 5) begin
        tr = c;
        break;
      end
    end
    chk("midrun_reached", tr >= 0, 1);
    @(posedge clkb);
    #1 rst = 1'b1;
    sbq.delete();
    @(posedge clkb);
    @(negedge clkb);
    chk("midrst_addrb", addrb, 0);
    chk("midrst_tvalid", bus.m_tvalid, 0);
    chk("midrst_tdata", bus.m_tdata, 0);
    chk("midrst_tlast", bus.m_tlast, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    @(posedge clkb);
    #1 rst = 1'b0;

    addr_trig = 12'd50;
    pnts_after_trig = 12'd50;
    push_expected(50, 50, 20);
    pulse_start(20);
    wait_done(12'd80, 200, 1'b1, ta, tv, td);
    chk("post_rst_lat_done", td - ta, 22);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
